// File: rtl/cm_sort_ser.sv
// cm_sort_ser: serializes sorted result vectors from cm_sort into a
// valid/ready element stream. Incoming vectors land in a small ring of
// vector slots. Elements of the head slot are emitted one per beat, with
// their position and a last flag. Vectors that arrive while every slot is
// occupied are dropped, and the drops are counted.
module cm_sort_ser #(
    parameter int DCNT    = 8,   // elements per vector (>=2)
    parameter int DWIDTH  = 16,  // bits per element
    parameter int BUF_CNT = 2,   // vector slots in the ring (>=1)
    parameter int DESC    = 0    // 0: emit position 0 first, 1: position DCNT-1 first
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_vld,
    input  logic [DCNT*DWIDTH-1:0]    i_data,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [DWIDTH-1:0]         o_data,
    output logic [$clog2(DCNT)-1:0]   o_idx,
    output logic                      o_last,
    output logic                      o_ovf,
    output logic [7:0]                o_drop_cnt,
    output logic                      o_busy
);

    localparam int CW = $clog2(DCNT);
    localparam int PW = (BUF_CNT > 1) ? $clog2(BUF_CNT) : 1;
    localparam int OW = $clog2(BUF_CNT + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DCNT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_CNT - 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(BUF_CNT);

    // Vector slots. They have no reset: contents are only read while the
    // slot is occupied.
    logic [DCNT*DWIDTH-1:0] slot_mem [BUF_CNT];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [OW-1:0] occ_reg, occ_next;
    logic          busy_reg;
    logic          ovf_reg;
    logic [7:0]    drop_cnt_reg, drop_cnt_next;

    logic              head_vld;
    logic              beat;
    logic              last_beat;
    logic              ring_full;
    logic              push;
    logic              drop;
    logic [CW-1:0]     pos;
    logic [DWIDTH-1:0] head_elem;
    logic [DCNT*DWIDTH-1:0] head_vec;
    logic [DWIDTH-1:0] elem_arr [DCNT];

    // The head slot is read combinationally. This lets a newly captured
    // vector appear on the next cycle. It also lets the next slot follow
    // o_last with no bubble.
    assign head_vec = slot_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DCNT; gi++) begin : g_elem
            assign elem_arr[gi] = head_vec[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    // In descending mode the counter still runs upward. Only the element
    // position it maps to is mirrored.
    assign pos       = (DESC != 0) ? (CNT_LAST - cnt_reg) : cnt_reg;
    assign head_elem = elem_arr[pos];

    assign head_vld  = (occ_reg != '0);
    assign beat      = head_vld && i_rdy;
    assign last_beat = beat && (cnt_reg == CNT_LAST);
    assign ring_full = (occ_reg == OCC_FULL);

    // A full ring still accepts a vector when the head slot is being freed
    // by its final beat in the same cycle.
    assign push = i_vld && (!ring_full || last_beat);
    assign drop = i_vld && ring_full && !last_beat;

    // Next-state for pointers, element counter, occupancy and drop counter.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        cnt_next      = cnt_reg;
        occ_next      = occ_reg;
        drop_cnt_next = drop_cnt_reg;

        if (beat) begin
            if (last_beat) begin
                cnt_next    = '0;
                rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end

        case ({push, last_beat})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase

        if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    // Control state. Reset empties the ring and abandons any partly
    // emitted vector.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            occ_reg      <= '0;
            busy_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            cnt_reg      <= cnt_next;
            occ_reg      <= occ_next;
            busy_reg     <= (occ_next != '0);
            ovf_reg      <= drop;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Capture an accepted vector into the slot at the write pointer.
    always_ff @(posedge i_clk) begin
        if (push) begin
            slot_mem[wr_ptr_reg] <= i_data;
        end
    end

    // The element outputs are forced to zero while the ring is empty. This
    // keeps them at 0 in reset even though the slots themselves are not
    // cleared.
    assign o_vld      = head_vld;
    assign o_data     = head_vld ? head_elem : '0;
    assign o_idx      = head_vld ? pos : '0;
    assign o_last     = head_vld && (cnt_reg == CNT_LAST);
    assign o_ovf      = ovf_reg;
    assign o_drop_cnt = drop_cnt_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_cm_sort_ser.sv
// Testbench for cm_sort_ser. An ascending and a descending instance share
// the same stimulus. Both are compared every cycle against a queue-based
// reference model.
module tb_cm_sort_ser;

    localparam int DCNT = 4;
    localparam int DW   = 16;
    localparam int BC   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 vld;
    logic                 rdy;
    logic [DCNT*DW-1:0]   din;

    logic          a_vld, a_last, a_ovf, a_busy;
    logic [DW-1:0] a_data;
    logic [1:0]    a_idx;
    logic [7:0]    a_drop;
    logic          d_vld, d_last, d_ovf, d_busy;
    logic [DW-1:0] d_data;
    logic [1:0]    d_idx;
    logic [7:0]    d_drop;

    cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DW), .BUF_CNT(BC), .DESC(0)) u_asc (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_data(din),
        .o_vld(a_vld), .i_rdy(rdy), .o_data(a_data), .o_idx(a_idx),
        .o_last(a_last), .o_ovf(a_ovf), .o_drop_cnt(a_drop), .o_busy(a_busy)
    );

    cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DW), .BUF_CNT(BC), .DESC(1)) u_desc (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_data(din),
        .o_vld(d_vld), .i_rdy(rdy), .o_data(d_data), .o_idx(d_idx),
        .o_last(d_last), .o_ovf(d_ovf), .o_drop_cnt(d_drop), .o_busy(d_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of stored vectors, emit position in the head,
    // last-cycle drop flag, and saturating drop count.
    logic [DCNT*DW-1:0] mq[$];
    int   m_pos  = 0;
    bit   m_ovf  = 1'b0;
    int   m_drop = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem_of(input logic [DCNT*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    task automatic check_outs();
        bit ev;
        logic [DCNT*DW-1:0] hv;
        ev = (mq.size() != 0);
        check_val("a_vld",  a_vld,  ev);
        check_val("d_vld",  d_vld,  ev);
        check_val("a_busy", a_busy, ev);
        check_val("d_busy", d_busy, ev);
        check_val("a_last", a_last, ev && (m_pos == DCNT-1));
        check_val("d_last", d_last, ev && (m_pos == DCNT-1));
        check_val("a_ovf",  a_ovf,  m_ovf);
        check_val("d_ovf",  d_ovf,  m_ovf);
        check_val("a_drop", a_drop, m_drop);
        check_val("d_drop", d_drop, m_drop);
        if (ev) begin
            hv = mq[0];
            check_val("a_idx",  a_idx,  m_pos);
            check_val("a_data", a_data, elem_of(hv, m_pos));
            check_val("d_idx",  d_idx,  DCNT-1-m_pos);
            check_val("d_data", d_data, elem_of(hv, DCNT-1-m_pos));
        end
    endtask

    // Advance the model across one rising edge, given that cycle's inputs.
    task automatic model_step(input bit v, input logic [DCNT*DW-1:0] d, input bit r);
        bit beat, lst, full;
        beat  = (mq.size() != 0) && r;
        lst   = beat && (m_pos == DCNT-1);
        full  = (mq.size() == BC);
        m_ovf = 1'b0;
        if (beat) begin
            if (lst) begin
                void'(mq.pop_front());
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (v) begin
            if (!full || lst) begin
                mq.push_back(d);
                $display("t=%0t push vec=%h occ=%0d", $time, d, mq.size());
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
                $display("t=%0t drop vec=%h drops=%0d", $time, d, m_drop);
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [DCNT*DW-1:0] d, input bit r);
        check_outs();
        vld = v;
        din = d;
        rdy = r;
        @(posedge clk);
        model_step(v, d, r);
        @(negedge clk);
    endtask

    // Assert reset and check right away, before any clock edge, that the
    // outputs have already cleared.
    task automatic apply_reset();
        rst_n = 1'b0;
        vld   = 1'b0;
        rdy   = 1'b0;
        din   = '0;
        #1;
        check_val("rst_vld",  a_vld,  1'b0);
        check_val("rst_busy", a_busy, 1'b0);
        check_val("rst_dvld", d_vld,  1'b0);
        check_val("rst_data", a_data, 16'd0);
        check_val("rst_idx",  a_idx,  2'd0);
        check_val("rst_last", a_last, 1'b0);
        check_val("rst_ovf",  a_ovf,  1'b0);
        check_val("rst_drop", a_drop, 8'd0);
        mq.delete();
        m_pos  = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [DCNT*DW-1:0] rand_vec();
        logic [DCNT*DW-1:0] v;
        for (int k = 0; k < DCNT; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    localparam logic [DCNT*DW-1:0] V1 = {16'd40, 16'd30, 16'd20, 16'd10};
    localparam logic [DCNT*DW-1:0] V2 = {16'd8, 16'd7, 16'd6, 16'd5};
    localparam logic [DCNT*DW-1:0] V3 = {16'd400, 16'd300, 16'd200, 16'd100};

    initial begin
        rst_n = 1'b0;
        vld   = 1'b0;
        rdy   = 1'b0;
        din   = '0;
        @(negedge clk);

        // One vector, consumer always ready.
        apply_reset();
        cycle(1'b1, V1, 1'b1);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Same vector, consumer ready on alternate cycles.
        apply_reset();
        cycle(1'b1, V1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, (i % 2) == 0);

        // Three back-to-back vectors: the third one is dropped.
        apply_reset();
        cycle(1'b1, V1, 1'b1);
        cycle(1'b1, V2, 1'b1);
        cycle(1'b1, V3, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1);
        check_val("t3_drop", a_drop, 8'd1);

        // Full ring: a new vector on the head's final beat is accepted.
        apply_reset();
        cycle(1'b1, V1, 1'b0);
        cycle(1'b1, V2, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, V3, 1'b1);
        check_val("t4_ovf", a_ovf, 1'b0);
        repeat (10) cycle(1'b0, '0, 1'b1);
        check_val("t4_drop", a_drop, 8'd0);

        // Reset after two beats. The next vector starts at position 0.
        apply_reset();
        cycle(1'b1, V1, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        apply_reset();
        cycle(1'b1, V2, 1'b1);
        check_val("t6_first", a_data, 16'd5);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // Drop counter saturates at 255.
        apply_reset();
        cycle(1'b1, rand_vec(), 1'b0);
        cycle(1'b1, rand_vec(), 1'b0);
        repeat (300) cycle(1'b1, rand_vec(), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_val("sat_drop", a_drop, 8'd255);

        // Random valid/ready soak.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) < 40, rand_vec(), $urandom_range(0, 99) < 60);
        end
        repeat (12) cycle(1'b0, '0, 1'b1);
        check_outs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
